// File: rtl/bin2oht_stream.sv
// Registered valid/ready binary-to-one-hot decoder; MODE=1 ORs a packet of beats into one mask.
// Optional feature macro: BIN2OHT_STREAM_ERR_EN adds the registered o_err flag.
module bin2oht_stream #(
    parameter  int WIDTH     = 16,
    parameter  int SPLIT     = 4,
    parameter  int MODE      = 0,
    localparam int WIDTH_LOG = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_vld,
    output logic                 i_rdy,
    input  logic [WIDTH_LOG-1:0] i_bin,
    input  logic                 i_lst,
    output logic                 o_vld,
    input  logic                 o_rdy,
    output logic [WIDTH-1:0]     o_oht
`ifdef BIN2OHT_STREAM_ERR_EN
    ,
    output logic                 o_err
`endif
);
    localparam int NGRP = (WIDTH + SPLIT - 1) / SPLIT;
    localparam int BW   = WIDTH_LOG + 1;

    logic [BW-1:0]    bin_x;
    logic [NGRP-1:0]  grp_hit;
    logic [WIDTH-1:0] dec;
    logic             in_xfer, out_xfer;
    logic             vld_q, vld_d;
    logic [WIDTH-1:0] oht_q, oht_d, acc_q, acc_d;

    assign bin_x = {1'b0, i_bin};

    // Two-level decode: a group range select, then the offset inside the group.
    // Indices past WIDTH hit no generated bit and fall out as all zeros.
    for (genvar g = 0; g < NGRP; g++) begin : g_grp
        localparam logic [BW-1:0] LO = BW'(g * SPLIT);
        localparam logic [BW-1:0] HI = BW'(g * SPLIT + SPLIT);
        assign grp_hit[g] = (bin_x >= LO) && (bin_x < HI);
        for (genvar j = 0; j < SPLIT; j++) begin : g_bit
            if (g * SPLIT + j < WIDTH) begin : g_on
                assign dec[g*SPLIT+j] = grp_hit[g] && ((bin_x - LO) == BW'(j));
            end
        end
    end

    assign i_rdy    = ~vld_q | o_rdy;
    assign in_xfer  = i_vld & i_rdy;
    assign out_xfer = vld_q & o_rdy;
    assign o_vld    = vld_q;
    assign o_oht    = oht_q;

    // acc only ever collects bits in MODE=1; in MODE=0 it stays zero so oht loads dec directly.
    always_comb begin
        vld_d = vld_q;
        oht_d = oht_q;
        acc_d = acc_q;
        if (out_xfer) vld_d = 1'b0;
        if (in_xfer) begin
            if (MODE == 0 || i_lst) begin
                oht_d = acc_q | dec;
                vld_d = 1'b1;
                acc_d = '0;
            end else begin
                acc_d = acc_q | dec;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= 1'b0;
            oht_q <= '0;
            acc_q <= '0;
        end else begin
            vld_q <= vld_d;
            oht_q <= oht_d;
            acc_q <= acc_d;
        end
    end

`ifdef BIN2OHT_STREAM_ERR_EN
    logic oor, dup, err_q, err_d, aerr_q, aerr_d;

    assign oor   = (bin_x >= BW'(WIDTH));
    assign dup   = |(acc_q & dec);
    assign o_err = err_q;

    // aerr_q is the sticky per-packet flag; it travels alongside acc.
    always_comb begin
        err_d  = err_q;
        aerr_d = aerr_q;
        if (in_xfer) begin
            if (MODE == 0 || i_lst) begin
                err_d  = aerr_q | oor | dup;
                aerr_d = 1'b0;
            end else begin
                aerr_d = aerr_q | oor | dup;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q  <= 1'b0;
            aerr_q <= 1'b0;
        end else begin
            err_q  <= err_d;
            aerr_q <= aerr_d;
        end
    end
`endif

endmodule

// File: tb/tb_bin2oht_stream.sv
// Scoreboard bench for bin2oht_stream: three instances (W16/M0, W16/M1, W10/M0) with
// random traffic, directed sweep/backpressure/packet cases and async reset checks.
module tb_bin2oht_stream;
    localparam int N = 3;
`ifdef BIN2OHT_STREAM_ERR_EN
    localparam bit ERR_CHK = 1'b1;
`else
    localparam bit ERR_CHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   go = 0;
    logic        vld_x [N];
    logic        irdy_x[N];
    logic [15:0] oht_x [N];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int n, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s inst%0d got %0h required %0h", nm, n, got, exp);
        end
    endtask

    for (genvar n = 0; n < N; n++) begin : g
        localparam int W = (n == 2) ? 10 : 16;
        localparam int M = (n == 1) ? 1 : 0;
        logic         i_vld = 1'b0, i_lst = 1'b0, o_rdy = 1'b1;
        logic         i_rdy, o_vld, err;
        logic [3:0]   i_bin = '0;
        logic [W-1:0] oht;
        logic         rdy_rand = 1'b0, rdy_fix = 1'b1;
        int           stage = 0, npop = 0;
        logic [16:0]  exp_q[$];
        int           pk[$];

        bin2oht_stream #(.WIDTH(W), .SPLIT(4), .MODE(M)) u_dut (
            .clk(clk), .rst_n(rst_n), .i_vld(i_vld), .i_rdy(i_rdy), .i_bin(i_bin),
            .i_lst(i_lst), .o_vld(o_vld), .o_rdy(o_rdy), .o_oht(oht)
`ifdef BIN2OHT_STREAM_ERR_EN
            , .o_err(err)
`endif
        );
`ifndef BIN2OHT_STREAM_ERR_EN
        assign err = 1'b0;
`endif
        assign vld_x[n]  = o_vld;
        assign irdy_x[n] = i_rdy;
        assign oht_x[n]  = 16'(oht);

        // Reference: a packet is the list of indices since the last closing beat.
        task automatic model(input logic [3:0] b, input logic l);
            logic [15:0] m;
            logic        e;
            pk.push_back(int'(b));
            if (M == 0 || l) begin
                m = '0;
                e = 1'b0;
                foreach (pk[i]) begin
                    if (pk[i] >= W) e = 1'b1;
                    else m[pk[i]] = 1'b1;
                    for (int j = 0; j < i; j++) if (pk[j] == pk[i]) e = 1'b1;
                end
                exp_q.push_back({e, m});
                pk.delete();
            end
        endtask

        task automatic send(input logic [3:0] b, input logic l);
            logic ok;
            ok = 1'b0;
            i_vld = 1'b1; i_bin = b; i_lst = l;
            for (int t = 0; t < 60 && !ok; t++) begin
                @(negedge clk);
                ok = i_rdy;
            end
            if (ok) model(b, l);
            else chk("send_timeout_i_rdy", n, 32'(i_rdy), 32'd1);
            @(posedge clk); #1;
            i_vld = 1'b0;
        endtask

        initial forever begin
            @(posedge clk); #2;
            o_rdy = rdy_rand ? ($urandom_range(3) != 0) : rdy_fix;
        end

        initial forever begin
            logic [16:0] e;
            @(negedge clk);
            if (rst_n && o_vld && o_rdy) begin
                npop++;
                if (exp_q.size() == 0) begin
                    chk("out_unexpected_vld", n, 32'(o_vld), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_oht", n, 32'(oht_x[n]), 32'(e[15:0]));
                    if (ERR_CHK) chk("out_err", n, 32'(err), 32'(e[16]));
                end
            end
        end

        initial begin
            int p0, c0;
            wait (go == 1);
            @(posedge clk); #1;
            p0 = npop; c0 = cyc;
            for (int k = 0; k < 16; k++) send(4'(k), 1'b1);
            chk("sweep_clocks", n, 32'(cyc - c0), 32'd16);
            @(negedge clk); #1;
            chk("sweep_outputs", n, 32'(npop - p0), 32'd16);

            @(posedge clk); #1;
            rdy_fix = 1'b0;
            send(4'd5, 1'b1);
            i_vld = 1'b1; i_bin = 4'd9; i_lst = 1'b1;
            repeat (3) begin
                @(negedge clk);
                chk("bp_vld", n, 32'(o_vld), 32'd1);
                chk("bp_oht", n, 32'(oht_x[n]), 32'h0020);
                chk("bp_i_rdy", n, 32'(i_rdy), 32'd0);
                @(posedge clk); #1;
            end
            rdy_fix = 1'b1;
            send(4'd9, 1'b1);
            @(negedge clk);
            chk("bp_next_vld", n, 32'(o_vld), 32'd1);
            chk("bp_next_oht", n, 32'(oht_x[n]), 32'h0200);

            @(posedge clk); #1;
            send(4'd1, 1'b0); send(4'd3, 1'b0); send(4'd3, 1'b0);
            send(4'd15, 1'b1); send(4'd0, 1'b1);

            rdy_rand = 1'b1;
            for (int i = 0; i < 300; i++) begin
                if ($urandom_range(3) == 0) begin @(posedge clk); #1; end
                send(4'($urandom_range(15)), (i == 299) ? 1'b1 : 1'($urandom_range(2) == 0));
            end
            rdy_rand = 1'b0; rdy_fix = 1'b1;
            repeat (3) @(posedge clk);
            #1;
            chk("drain_queue_empty", n, 32'(exp_q.size()), 32'd0);
            rdy_fix = 1'b0;
            send(4'd2, 1'b1);
            stage = 1;

            wait (go == 2);
            exp_q.delete(); pk.delete();
            rdy_fix = 1'b1;
            @(posedge clk); #1;
            send(4'd6, 1'b0);
            repeat (2) @(posedge clk);
            #1;
            stage = 2;

            wait (go == 3);
            exp_q.delete(); pk.delete();
            @(posedge clk); #1;
            send(4'd9, 1'b1);
            repeat (3) @(posedge clk);
            #1;
            chk("final_queue_empty", n, 32'(exp_q.size()), 32'd0);
            stage = 3;
        end
    end

    task automatic wait_stage(input int s);
        int t;
        t = 0;
        while (!(g[0].stage >= s && g[1].stage >= s && g[2].stage >= s) && t < 20000) begin
            @(posedge clk);
            t++;
        end
        if (t >= 20000) chk("stage_timeout", s, 32'(t), 32'd0);
    endtask

    task automatic chk_reset(input string tag);
        for (int n = 0; n < N; n++) begin
            chk({tag, "_o_vld"}, n, 32'(vld_x[n]), 32'd0);
            chk({tag, "_o_oht"}, n, 32'(oht_x[n]), 32'd0);
            chk({tag, "_i_rdy"}, n, 32'(irdy_x[n]), 32'd1);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk_reset("reset_init");
        rst_n = 1'b1;
        go = 1;

        wait_stage(1);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk_reset("reset_mid_stream");
        @(posedge clk); #1;
        rst_n = 1'b1;
        go = 2;

        wait_stage(2);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        go = 3;

        wait_stage(3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
